// File: rtl/zilla_mul_pkg.sv
// Shared constants for the Vedic multiplier pipeline: latency, nibble size and
// the set of operand widths the pipeline can be built for.
package zilla_mul_pkg;

  localparam int MUL_LATENCY = 3;
  localparam int NIBBLE_W    = 4;

  // Bit n set means WIDTH=n is a legal operand width (8, 16, 32).
  localparam logic [63:0] LEGAL_WIDTH_MASK = 64'h0000_0001_0001_0100;

  function automatic bit width_is_legal(input int w);
    if (w <= 0 || w >= 64) return 1'b0;
    return LEGAL_WIDTH_MASK[w[5:0]];
  endfunction

endpackage

// File: rtl/vedic_4x4.sv
// 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from four 2x2 blocks;
// purely combinational.
module vedic_4x4
  import zilla_mul_pkg::*;
(
  input  logic [NIBBLE_W-1:0]   a_i,
  input  logic [NIBBLE_W-1:0]   b_i,
  output logic [2*NIBBLE_W-1:0] p_o
);

  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic c0, s1, k1, hh;
    c0 = x[0] & y[0];
    s1 = (x[1] & y[0]) ^ (x[0] & y[1]);
    k1 = (x[1] & y[0]) & (x[0] & y[1]);
    hh = x[1] & y[1];
    return {hh & k1, hh ^ k1, s1, c0};
  endfunction

  logic [3:0] q_ll, q_hl, q_lh, q_hh;

  assign q_ll = vedic_2x2(a_i[1:0], b_i[1:0]);
  assign q_hl = vedic_2x2(a_i[3:2], b_i[1:0]);
  assign q_lh = vedic_2x2(a_i[1:0], b_i[3:2]);
  assign q_hh = vedic_2x2(a_i[3:2], b_i[3:2]);

  assign p_o = {4'd0, q_ll} + {2'd0, q_hl, 2'd0} + {2'd0, q_lh, 2'd0} + {q_hh, 4'd0};

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage signed/unsigned WIDTHxWIDTH multiplier: sign/magnitude capture,
// registered nibble partial products, then weighted accumulation with sign restore.
module vedic_mul_pipe
  import zilla_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   tag_out
);

  localparam int NN  = WIDTH / NIBBLE_W;
  localparam int PW  = 2 * WIDTH;
  localparam int PPW = 2 * NIBBLE_W;

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("vedic_mul_pipe: WIDTH must be 8, 16 or 32");
  end

  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v,
                                               input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [PW-1:0] restore_sign(input logic [PW-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic             en;
  logic             vld_p0, vld_p1, vld_p2;
  logic             a_neg, b_neg;
  logic             neg_p0, neg_p1;
  logic [WIDTH-1:0] mag_a_p0, mag_b_p0;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
  logic [PPW-1:0]   pp_d  [NN][NN];
  logic [PPW-1:0]   pp_p1 [NN][NN];
  logic [PW-1:0]    acc_d, prod_d, result_p2;

  assign en       = ready_out | ~valid_out;
  assign ready_in = en;
  assign a_neg    = signed_in & a_in[WIDTH-1];
  assign b_neg    = signed_in & b_in[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= valid_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // S1: operand capture as sign + magnitude (most-negative maps to 2^(WIDTH-1))
  always_ff @(posedge clk) begin
    if (en) begin
      mag_a_p0 <= abs_mag(a_in, a_neg);
      mag_b_p0 <= abs_mag(b_in, b_neg);
      neg_p0   <= a_neg ^ b_neg;
      tag_p0   <= tag_in;
    end
  end

  // S2: every nibble pair multiplied and registered
  for (genvar i = 0; i < NN; i++) begin : g_row
    for (genvar j = 0; j < NN; j++) begin : g_col
      vedic_4x4 u_pp (
        .a_i (mag_a_p0[NIBBLE_W*i +: NIBBLE_W]),
        .b_i (mag_b_p0[NIBBLE_W*j +: NIBBLE_W]),
        .p_o (pp_d[i][j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NN; i++)
        for (int j = 0; j < NN; j++)
          pp_p1[i][j] <= pp_d[i][j];
      neg_p1 <= neg_p0;
      tag_p1 <= tag_p0;
    end
  end

  // S3: full-width weighted sum of partial products, then sign restore
  always_comb begin
    acc_d = '0;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        acc_d = acc_d + (PW'(pp_p1[i][j]) << (NIBBLE_W * (i + j)));
    prod_d = restore_sign(acc_d, neg_p1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_p2 <= '0;
      tag_p2    <= '0;
    end else if (en) begin
      result_p2 <= prod_d;
      tag_p2    <= tag_p1;
    end
  end

  assign valid_out = vld_p2;
  assign result    = result_p2;
  assign tag_out   = tag_p2;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench driving WIDTH=8/16/32 pipelines in lockstep against a queue-based
// arithmetic reference, plus literal checks of the documented vectors.
module tb_vedic_mul_pipe;

  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst, valid_in, signed_in, ready_out;
  logic [31:0]       a_in, b_in;
  logic [TAG_W-1:0]  tag_in;

  logic              rdy8, vo8, rdy16, vo16, rdy32, vo32;
  logic [15:0]       res8;
  logic [31:0]       res16;
  logic [63:0]       res32;
  logic [TAG_W-1:0]  tg8, tg16, tg32;

  always #5 clk = ~clk;

  vedic_mul_pipe #(.WIDTH(8), .TAG_W(TAG_W)) u8 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy8),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .signed_in(signed_in), .tag_in(tag_in),
    .valid_out(vo8), .ready_out(ready_out), .result(res8), .tag_out(tg8));

  vedic_mul_pipe #(.WIDTH(16), .TAG_W(TAG_W)) u16 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy16),
    .a_in(a_in[15:0]), .b_in(b_in[15:0]), .signed_in(signed_in), .tag_in(tag_in),
    .valid_out(vo16), .ready_out(ready_out), .result(res16), .tag_out(tg16));

  vedic_mul_pipe #(.WIDTH(32), .TAG_W(TAG_W)) u32 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy32),
    .a_in(a_in), .b_in(b_in), .signed_in(signed_in), .tag_in(tag_in),
    .valid_out(vo32), .ready_out(ready_out), .result(res32), .tag_out(tg32));

  typedef struct {
    logic [15:0]      r8;
    logic [31:0]      r16;
    logic [63:0]      r32;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference product of w-bit operands, taken modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    logic [63:0] m, ea, eb, t, p;
    m  = (w >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ea = {32'd0, a} & m;
    eb = {32'd0, b} & m;
    t  = ea >> (w - 1);
    if (s && t[0]) ea = ea | ~m;
    t  = eb >> (w - 1);
    if (s && t[0]) eb = eb | ~m;
    p  = ea * eb;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_res8;
  logic [3:0]  prev_tg8;

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] r;
    if (rst) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      chk("lockstep_vo16", 64'(vo16), 64'(vo8));
      chk("lockstep_vo32", 64'(vo32), 64'(vo8));
      chk("lockstep_rdy16", 64'(rdy16), 64'(rdy8));
      chk("lockstep_rdy32", 64'(rdy32), 64'(rdy8));
      if (prev_hold) begin
        chk("hold_valid", 64'(vo8), 64'd1);
        chk("hold_result", 64'(res8), 64'(prev_res8));
        chk("hold_tag", 64'(tg8), 64'(prev_tg8));
      end
      if (vo8 && ready_out) begin
        chk("output_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("res8", 64'(res8), 64'(e.r8));
          chk("res16", 64'(res16), 64'(e.r16));
          chk("res32", res32, e.r32);
          chk("tag8", 64'(tg8), 64'(e.tag));
          chk("tag32", 64'(tg32), 64'(e.tag));
        end
      end
      if (valid_in && rdy8) begin
        r = ref_mul(a_in, b_in, signed_in, 8);  e.r8  = r[15:0];
        r = ref_mul(a_in, b_in, signed_in, 16); e.r16 = r[31:0];
        e.r32 = ref_mul(a_in, b_in, signed_in, 32);
        e.tag = tag_in;
        sb.push_back(e);
        acc_cnt++;
      end
      prev_hold = vo8 & ~ready_out;
      prev_res8 = res8;
      prev_tg8  = tg8;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] t);
    bit done;
    done      = 1'b0;
    valid_in  = 1'b1;
    a_in      = a;
    b_in      = b;
    signed_in = s;
    tag_in    = t;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = rdy8;
      @(posedge clk);
      #1;
    end
    chk("issue_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stall_res;
    int          target;

    rst = 1'b1; valid_in = 1'b0; signed_in = 1'b0; ready_out = 1'b1;
    a_in = '0; b_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_in", 64'(rdy8), 64'd1);
    chk("reset_valid_out", 64'(vo8), 64'd0);
    chk("reset_result8", 64'(res8), 64'd0);
    chk("reset_result32", res32, 64'd0);
    chk("reset_tag", 64'(tg8), 64'd0);

    // Single unsigned op: latency exactly 3.
    @(posedge clk); #1;
    issue(32'h0000_00FF, 32'h0000_00FF, 1'b0, 4'd3);
    valid_in = 1'b0;
    @(negedge clk); chk("lat_c1_valid", 64'(vo8), 64'd0);
    @(negedge clk); chk("lat_c2_valid", 64'(vo8), 64'd0);
    @(negedge clk); chk("lat_c3_valid", 64'(vo8), 64'd1);
    chk("u8_ff_ff", 64'(res8), 64'h0000_0000_0000_FE01);
    chk("u8_ff_ff_tag", 64'(tg8), 64'd3);
    chk("u32_ff_ff", res32, 64'h0000_0000_0000_FE01);

    // Signed back-to-back, results on consecutive cycles.
    issue(32'hFFFF_FF80, 32'hFFFF_FF80, 1'b1, 4'd1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4'd2);
    issue(32'h0000_007F, 32'hFFFF_FF80, 1'b1, 4'd4);
    valid_in = 1'b0;
    @(negedge clk);
    chk("s8_m128_m128", 64'(res8), 64'h4000);
    chk("s32_m128_m128", res32, 64'h4000);
    @(negedge clk);
    chk("s8_m1_1_valid", 64'(vo8), 64'd1);
    chk("s8_m1_1", 64'(res8), 64'hFFFF);
    @(negedge clk);
    chk("s8_127_m128_valid", 64'(vo8), 64'd1);
    chk("s8_127_m128", 64'(res8), 64'hC080);
    chk("s8_127_m128_tag", 64'(tg8), 64'd4);

    // 32-bit extremes.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd6);
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("u32_max", res32, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("s32_m1_m1", res32, 64'h0000_0000_0000_0001);
    chk("s8_m1_m1", 64'(res8), 64'h0001);
    drain();

    // 10-op stream with ready_out low for four cycles.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          issue($urandom, $urandom, 1'(i % 2), 4'(i));
        valid_in = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) stall_res = res8;
          else chk("stall_result_stable", 64'(res8), 64'(stall_res));
          chk("stall_ready_in", 64'(rdy8), 64'd0);
          chk("stall_valid_out", 64'(vo8), 64'd1);
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight during a stall.
    @(posedge clk); #1;
    issue(32'd7, 32'd9, 1'b0, 4'd10);
    issue(32'd11, 32'd3, 1'b0, 4'd11);
    issue(32'd200, 32'd2, 1'b0, 4'd12);
    valid_in = 1'b0;
    ready_out = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", 64'(vo8), 64'd0);
    chk("rst_flush_result", 64'(res8), 64'd0);
    chk("rst_ready_in", 64'(rdy8), 64'd1);
    repeat (6) @(negedge clk);
    chk("rst_no_ghosts", 64'(vo8), 64'd0);
    @(posedge clk); #1;
    issue(32'd12, 32'd13, 1'b0, 4'd9);
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_valid", 64'(vo8), 64'd1);
    chk("post_rst_result", 64'(res8), 64'h009C);
    chk("post_rst_tag", 64'(tg8), 64'd9);
    drain();

    // Random mixed traffic with random backpressure.
    target = acc_cnt + 10000;
    for (int cyc = 0; cyc < 60000 && acc_cnt < target; cyc++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      a_in      = $urandom;
      b_in      = $urandom;
      signed_in = 1'($urandom_range(0, 1));
      tag_in    = 4'($urandom_range(0, 15));
      ready_out = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    chk("random_ops_accepted", 64'(acc_cnt >= target), 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
